da_sample_serializer: RTL
=========================

Name: da_sample_serializer

Overview:
Front end of the distributed-arithmetic FIR datapath. Accepts parallel signed samples over a valid/ready handshake and emits them bit-serially, LSB first, one bit per enabled cycle. Each bit carries first/last markers so the DA LUT/shift-accumulator can align bit-planes and subtract the sign-bit plane. Sits between the sample source and the DA tap-address/accumulate stage, and is the counterpart to the serial-to-parallel accumulator at the filter output.

Parameters:
DATA_W, 12, sample width in bits (two's complement); must be >= 2.
CNT_W, 4, bit-counter width; must satisfy 2**CNT_W >= DATA_W.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  source presents a sample on in_data.
in_ready  output  1  block can accept a sample this cycle.
in_data  input  DATA_W  signed sample.
bit_ready  input  1  downstream consumes the current bit this cycle; low = stall.
bit_valid  output  1  bit_out is meaningful.
bit_out  output  1  current serial bit, LSB first.
bit_first  output  1  current bit is bit 0 of a sample.
bit_last  output  1  current bit is bit DATA_W-1 (sign bit; the DA stage subtracts this plane).
busy  output  1  SHIFT state or hold register occupied.

Behaviour:
- Clock: clk only. Reset: rst, asynchronous and active-high. Everything else is synchronous to clk.
- State: shift register sh[DATA_W-1:0], counter cnt[CNT_W-1:0], hold register hold_data[DATA_W-1:0], flag hold_full, FSM {IDLE, SHIFT}.
- Reset values: FSM=IDLE, sh=0, cnt=0, hold_data=0, hold_full=0.
- Outputs during and after reset: in_ready=1, bit_valid=0, bit_out=0, bit_first=0, bit_last=0, busy=0.
- in_ready = ~hold_full. It depends only on registered state, with no combinational path from bit_ready.
- Accept: in_valid & in_ready at an edge writes in_data into hold_data and sets hold_full.
- Output decode:
  - bit_valid = (FSM==SHIFT).
  - bit_out = sh[0] when SHIFT, else 0.
  - bit_first = SHIFT & cnt==0.
  - bit_last = SHIFT & cnt==DATA_W-1.
  - busy = SHIFT | hold_full.
- IDLE, with hold_full: next edge loads sh<=hold_data, cnt<=0, clears hold_full, and moves to SHIFT. bit_ready is ignored in IDLE.
- IDLE, without hold_full: remain in IDLE.
- SHIFT with bit_ready=0: all state holds. Outputs stay stable.
- SHIFT with bit_ready=1 and cnt<DATA_W-1: sh<=sh>>1, cnt<=cnt+1.
- SHIFT with bit_ready=1 and cnt==DATA_W-1:
  - If hold_full: load sh<=hold_data, cnt<=0, clear hold_full, stay in SHIFT. This gives a gapless stream.
  - Else: go to IDLE.
- Latency: a sample accepted at edge N presents bit 0 in the cycle following edge N+1.
- Throughput: one sample per DATA_W bit_ready cycles, back-to-back with no idle bit between samples.
- Hold and accept in one edge: in_ready is low whenever hold_full=1, so an unload and an accept never happen at the same edge. A new sample is accepted on the cycle after the unload. This still sustains full throughput because DATA_W >= 2.
- Sign handling: bits are raw two's complement. No sign extension and no inversion; the DA stage applies the subtraction on bit_last.
- Reset mid-operation: asynchronous clear. The in-flight sample and the held sample are discarded, and no partial frame is resumed.
- cnt never exceeds DATA_W-1, and no wrap beyond it is permitted.

Decomposition:
- Shared package da_fir_pkg holds:
  - DATA_W=12, COEF_W=17, OUT_W=29, TAPS=41, HALF_TAPS=21.
  - Enum typedef ser_state_t {IDLE, SHIFT}.
- Datapath plus FSM fit in one module of about 150 lines, so no sub-module is required.
- The hold register may optionally be factored as da_skid_reg (1-entry valid/ready buffer) for reuse by the output accumulator.

Test Plan:
- Single sample: after reset, drive in_data=12'h801 with in_valid for 1 cycle and bit_ready=1. Required response:
  - bit_valid high for exactly 12 cycles, starting 2 cycles after acceptance.
  - bit_out sequence 1,0,0,0,0,0,0,0,0,0,0,1.
  - bit_first only on cycle 1, bit_last only on cycle 12.
  - Then IDLE with busy=0.
- Back-to-back: offer 12'h0A5, then 12'hFFF as soon as in_ready returns, with bit_ready=1. Required response:
  - 24 contiguous bit_valid cycles.
  - Bits 1,0,1,0,0,1,0,1,0,0,0,0 followed by twelve 1s.
  - bit_first on cycles 1 and 13, bit_last on cycles 12 and 24.
- Backpressure: during 12'h555, hold bit_ready=0 for 5 cycles at bit 3. Required response:
  - bit_out, bit_first, bit_last and cnt frozen through the stall.
  - Resuming yields the uninterrupted pattern 1,0,1,0,... with 12 total consumed bits.
- Hold full: while shifting sample A, accept B; keep in_valid high with C. Required response:
  - in_ready=0 until the edge where B loads.
  - C is accepted the next cycle.
  - No sample is lost or duplicated; compare the deserialized output against A,B,C.
- Reset mid-frame: assert rst asynchronously (between edges) at bit 6 of 12'h7FF while a sample is held. Required response:
  - All outputs drop to reset values immediately, and in_ready=1.
  - After release, a new 12'h001 serializes cleanly: 1 followed by eleven 0s.
- Random soak: 10k random samples ($random) with random bit_ready. A reference deserializer (sign on bit_last) must match the input stream exactly, with zero mismatches.

Source files
------------

// File: rtl/da_fir_pkg.sv
// Shared constants and types for the distributed-arithmetic FIR datapath.
package da_fir_pkg;

  localparam int DATA_W    = 12;
  localparam int COEF_W    = 17;
  localparam int OUT_W     = 29;
  localparam int TAPS      = 41;
  localparam int HALF_TAPS = 21;

  // Serializer control: idle, or streaming a sample out bit by bit.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/da_sample_serializer.sv
// Parallel-to-serial front end of the DA FIR: accepts signed samples over
// valid/ready and streams them LSB first with first/last bit-plane markers.
// A one-entry hold register lets the next sample load at the last bit of the
// current one, so consecutive samples leave with no idle bit between them.
module da_sample_serializer #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              bit_ready,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              bit_first,
  output logic              bit_last,
  output logic              busy
);

  import da_fir_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_full_q, hold_full_d;

  logic in_ready_q, in_ready_d;
  logic bit_valid_q, bit_valid_d;
  logic bit_out_q, bit_out_d;
  logic bit_first_q, bit_first_d;
  logic bit_last_q, bit_last_d;
  logic busy_q, busy_d;

  logic accept_s;

  // in_ready comes from a flop, so accepting never depends on bit_ready.
  assign accept_s = in_valid & in_ready_q;

  // Next-state logic: shift/load/unload plus hold-register fill.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          sh_d        = hold_data_q;
          cnt_d       = ZERO_CNT;
          hold_full_d = 1'b0;
          state_d     = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (!bit_ready) begin
          state_d = SHIFT;
        end else if (cnt_q != LAST_CNT) begin
          sh_d  = {1'b0, sh_q[DATA_W-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
        end else if (hold_full_q) begin
          // Sign bit consumed and the next sample is waiting: chain it in.
          sh_d        = hold_data_q;
          cnt_d       = ZERO_CNT;
          hold_full_d = 1'b0;
          state_d     = SHIFT;
        end else begin
          cnt_d   = ZERO_CNT;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = ZERO_CNT;
      end
    endcase

    // Accept only happens with the hold register empty, so it never collides
    // with an unload of that register in the same cycle.
    if (accept_s) begin
      hold_data_d = in_data;
      hold_full_d = 1'b1;
    end else begin
      hold_data_d = hold_data_d;
    end
  end

  // Output decode from next state, so the ports come straight off flops.
  always_comb begin
    in_ready_d  = ~hold_full_d;
    bit_valid_d = (state_d == SHIFT);
    busy_d      = (state_d == SHIFT) | hold_full_d;
    if (state_d == SHIFT) begin
      bit_out_d   = sh_d[0];
      bit_first_d = (cnt_d == ZERO_CNT);
      bit_last_d  = (cnt_d == LAST_CNT);
    end else begin
      bit_out_d   = 1'b0;
      bit_first_d = 1'b0;
      bit_last_d  = 1'b0;
    end
  end

  // State and output registers; reset discards any in-flight or held sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= {DATA_W{1'b0}};
      cnt_q       <= ZERO_CNT;
      hold_data_q <= {DATA_W{1'b0}};
      hold_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_first_q <= 1'b0;
      bit_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      in_ready_q  <= in_ready_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
      bit_first_q <= bit_first_d;
      bit_last_q  <= bit_last_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_out_q;
  assign bit_first = bit_first_q;
  assign bit_last  = bit_last_q;
  assign busy      = busy_q;

endmodule
